// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the branch predictor, the control unit and the NPC
// logic: 2-bit saturating counter states and the sequential PC increment.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  // Counter encoding: the MSB is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not taken
    WNT = 2'b01,  // weakly not taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } ctr_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Fall-through address of the instruction at pc (wraps modulo 2^32).
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// -----------------------------------------------------------------------------
// bp_sat_ctr
// Next-state function of a 2-bit saturating counter.
//   cur : current counter state
//   inc : count up, saturating at ST
//   dec : count down, saturating at SNT
//   nxt : resulting counter state (equals cur when neither or both requested)
// -----------------------------------------------------------------------------
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] nxt
);

  always_comb begin
    // NOTE: assigning a default before any branch keeps every path driven,
    // so no latch is inferred.
    nxt = cur;
    if (inc && !dec && (cur != ST)) begin
      nxt = cur + 2'd1;
    end else if (dec && !inc && (cur != SNT)) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with 2-bit saturating counters. IF-stage lookup is
// combinational; EX-stage updates train the table and raise a registered
// one-cycle mispredict pulse with the corrected next PC.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   pred_en, pred_pc              IF lookup request
//   pred_taken, pred_target       combinational prediction
//   upd_valid, upd_pc, upd_taken, upd_target
//                                 resolved branch from EX
//   upd_pred_taken, upd_pred_target
//                                 prediction carried down with that branch
//   mispredict, redirect_pc       registered flush request and correct PC
//   mispredict_cnt                saturating mispredict count (debug)
//
// ENTRIES must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_en,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] mispredict_cnt
);

  // Table storage (flip-flops so lookup is combinational and reset clears it).
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;
  logic             pred_hit;

  assign pred_idx    = pred_pc[IDX_W+1:2];
  assign pred_tag    = pred_pc[31:IDX_W+2];
  assign pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken  = pred_en && pred_hit && ctr_q[pred_idx][1];
  assign pred_target = pred_taken ? tgt_q[pred_idx] : seq_pc(pred_pc);

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       ctr_nxt;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  bp_sat_ctr u_sat_ctr (
    .cur (ctr_q[upd_idx]),
    .inc (upd_taken),
    .dec (!upd_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this array is reset on purpose (it is a flip-flop table whose
      // valid bits must clear); a RAM-backed table could not be reset this way.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
        if (upd_taken) begin
          tgt_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        // Allocate on a taken miss, evicting whatever aliased here.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        ctr_q[upd_idx]   <= WT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict detection: compare next-PC values, so a taken prediction with
  // the wrong target also counts, and a taken branch to its own fall-through
  // address does not.
  // ---------------------------------------------------------------------------
  logic [31:0] actual_pc;
  logic [31:0] predicted_pc;
  logic        miss_now;

  assign actual_pc    = upd_taken      ? upd_target      : seq_pc(upd_pc);
  assign predicted_pc = upd_pred_taken ? upd_pred_target : seq_pc(upd_pc);
  assign miss_now     = upd_valid && (actual_pc != predicted_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      mispredict <= miss_now;
      if (miss_now) begin
        redirect_pc <= actual_pc;
        if (mispredict_cnt != 16'hFFFF) begin
          mispredict_cnt <= mispredict_cnt + 16'd1;
        end
      end
    end
  end

  // Word-offset bits of the PCs carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed, table-driven bench for branch_predictor (ENTRIES=16), plus
// hand-written sequences for asynchronous reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        pred_en;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .pred_en         (pred_en),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pred_en;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        exp_pt;     // combinational, sampled before the edge
    logic [31:0] exp_ptgt;
    logic        exp_mp;     // registered, sampled after the edge
    logic [31:0] exp_redir;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  initial begin
    // 0x100 and 0x140 both map to index 0 (tags 4 and 5).
    //            en  pred_pc       uv  upd_pc        tk  tgt     ptk ptgt     exp_pt exp_ptgt      mp  redir   cnt
    vecs[0]  = '{1'b1, 32'h100,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104,      1'b0, 32'h0,   16'd0};
    // Cold taken branch; same-cycle lookup still sees the empty table.
    vecs[1]  = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h104,      1'b1, 32'h200, 16'd1};
    vecs[2]  = '{1'b1, 32'h100,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200,      1'b0, 32'h200, 16'd1};
    // Not taken three times: WT->WNT (mispredict), WNT->SNT, SNT->SNT.
    vecs[3]  = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200,      1'b1, 32'h104, 16'd2};
    vecs[4]  = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104,      1'b0, 32'h104, 16'd2};
    vecs[5]  = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104,      1'b0, 32'h104, 16'd2};
    // Taken twice from SNT: SNT->WNT (still predicts not taken), WNT->WT.
    vecs[6]  = '{1'b0, 32'h100,      1'b1, 32'h100,     1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 32'h104,      1'b1, 32'h300, 16'd3};
    vecs[7]  = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b1, 32'h300, 1'b0, 32'h0,   1'b0, 32'h104,      1'b1, 32'h300, 16'd4};
    vecs[8]  = '{1'b1, 32'h100,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300,      1'b0, 32'h300, 16'd4};
    // pred_en low masks a hit; correct prediction gives no mispredict; WT->ST.
    vecs[9]  = '{1'b0, 32'h100,      1'b1, 32'h100,     1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h104,      1'b0, 32'h300, 16'd4};
    // Direction right, target wrong -> mispredict. ST saturates.
    vecs[10] = '{1'b1, 32'h100,      1'b1, 32'h100,     1'b1, 32'h300, 1'b1, 32'h304, 1'b1, 32'h300,      1'b1, 32'h300, 16'd5};
    // Alias: 0x140 evicts 0x100.
    vecs[11] = '{1'b1, 32'h100,      1'b1, 32'h140,     1'b1, 32'h500, 1'b0, 32'h0,   1'b1, 32'h300,      1'b1, 32'h500, 16'd6};
    vecs[12] = '{1'b1, 32'h100,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104,      1'b0, 32'h500, 16'd6};
    vecs[13] = '{1'b1, 32'h140,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500,      1'b0, 32'h500, 16'd6};
    // Miss, not taken: table untouched.
    vecs[14] = '{1'b1, 32'h140,      1'b1, 32'h100,     1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500,      1'b0, 32'h500, 16'd6};
    vecs[15] = '{1'b1, 32'h140,      1'b0, 32'h0,       1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h500,      1'b0, 32'h500, 16'd6};
    // PC+4 wraps to 0 on both the lookup and the mispredict compare.
    vecs[16] = '{1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC,1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,        1'b0, 32'h500, 16'd6};
  end

  task automatic drive(input vec_t v);
    pred_en         = v.pred_en;
    pred_pc         = v.pred_pc;
    upd_valid       = v.upd_valid;
    upd_pc          = v.upd_pc;
    upd_taken       = v.upd_taken;
    upd_target      = v.upd_target;
    upd_pred_taken  = v.upd_pred_taken;
    upd_pred_target = v.upd_pred_target;
  endtask

  initial begin
    rst             = 1'b0;
    pred_en         = 1'b0;
    pred_pc         = '0;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- table-driven vectors ------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d pred_taken", i),  32'(pred_taken),  32'(vecs[i].exp_pt));
      check($sformatf("v%0d pred_target", i), pred_target,      vecs[i].exp_ptgt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d mispredict", i),     32'(mispredict),     32'(vecs[i].exp_mp));
      check($sformatf("v%0d redirect_pc", i),    redirect_pc,         vecs[i].exp_redir);
      check($sformatf("v%0d mispredict_cnt", i), 32'(mispredict_cnt), 32'(vecs[i].exp_cnt));
    end

    // ---- asynchronous reset mid-update ---------------------------------
    // 0x180 (index 0, tag 6) allocated with a mispredict.
    pred_en = 1'b1; pred_pc = 32'h180;
    upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h700;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    @(posedge clk);
    #1;
    check("rst pre mispredict", 32'(mispredict), 32'd1);
    check("rst pre cnt", 32'(mispredict_cnt), 32'd7);
    check("rst pre pred_target", pred_target, 32'h700);
    // Another update is in flight when reset hits between edges.
    upd_pc = 32'h1C0; upd_target = 32'h800;
    #3;
    rst = 1'b0;
    #1;
    check("rst async pred_taken", 32'(pred_taken), 32'd0);
    check("rst async pred_target", pred_target, 32'h184);
    check("rst async mispredict", 32'(mispredict), 32'd0);
    check("rst async redirect_pc", redirect_pc, 32'h0);
    check("rst async cnt", 32'(mispredict_cnt), 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pred_pc = 32'h1C0;
    #1;
    check("rst discarded update pred_target", pred_target, 32'h1C4);
    @(posedge clk);
    #1;
    check("rst post mispredict", 32'(mispredict), 32'd0);
    check("rst post cnt", 32'(mispredict_cnt), 32'd0);

    // ---- mispredict counter saturation ---------------------------------
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat cnt 65534", 32'(mispredict_cnt), 32'h0000FFFE);
    @(posedge clk);
    #1;
    check("sat cnt 65535", 32'(mispredict_cnt), 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat cnt held", 32'(mispredict_cnt), 32'h0000FFFF);
    check("sat mispredict", 32'(mispredict), 32'd1);
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat idle mispredict", 32'(mispredict), 32'd0);
    check("sat idle redirect_pc", redirect_pc, 32'h200);
    check("sat idle cnt", 32'(mispredict_cnt), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
